// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud settings.
// The receive side will import this package as well.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_W               = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200

  // Counter width for a divider of n cycles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_uart_tx_if.sv
// Byte-in / serial-out bundle between the data-select mux, the control
// register logic and the transmit serializer.
interface module_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_i;   // byte to send, from the data-select mux
  logic              send_i;   // send request, level or pulse
  logic              tx_o;     // serial line, idles high
  logic              busy_o;   // frame in progress
  logic              done_o;   // one-cycle completion pulse

  // Requester side: supplies the byte and request, watches status.
  modport master (
    output data_i, send_i,
    input  tx_o, busy_o, done_o
  );

  // Serializer side.
  modport slave (
    input  data_i, send_i,
    output tx_o, busy_o, done_o
  );
endinterface

// File: rtl/module_uart_baud_tick.sv
// Bit-period divider: counts clock cycles and flags the last cycle of each
// serial bit. The counter wraps by itself after the tick and can be held at
// zero with clr_i so a new bit period always starts from a clean count.
module module_uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Last cycle of the current bit period.
  assign tick_o = (cnt == CNT_LAST);

  // Count up, returning to zero on reset, explicit clear or end of period.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i || tick_o) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/module_uart_tx.sv
// UART 8N1 transmit serializer. A send request seen in IDLE latches the
// byte and emits start bit, 8 data bits LSB-first, and stop bit on tx_o,
// each held CLKS_PER_BIT cycles. busy_o covers the frame; done_o pulses on
// the first IDLE cycle afterwards. Requests during a frame are dropped.
module module_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  module_uart_tx_if.slave   bus
);

  // Refuse to elaborate an unusable divider or an unsupported frame width.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("module_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_W != 8) begin : g_bad_dw
    $error("module_uart_tx: DATA_W must be 8");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              tx;
  logic              busy;
  logic              done;
  logic              tick;
  logic              baud_clr;

  // The divider is held cleared while idle so START always begins at
  // count zero; every later state change happens on a tick, where the
  // divider has just wrapped to zero on its own.
  assign baud_clr = (state == IDLE);

  module_uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (baud_clr),
    .tick_o  (tick)
  );

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.send_i) begin
            shreg   <= bus.data_i;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              // Present the next bit while shifting it into position 0.
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_o   = tx;
  assign bus.busy_o = busy;
  assign bus.done_o = done;

endmodule

// File: tb/tb_module_uart_tx.sv
// Self-checking bench for module_uart_tx with CLKS_PER_BIT=4. A reference
// model tracks each frame as a cycle offset from its start edge and derives
// line/status values from the 10-bit frame image; frames are also decoded
// straight from a tx_o log and compared with the byte sent.
module tb_module_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;   // frame length in cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  module_uart_tx_if #(.DATA_W(8)) bus ();

  module_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: m_t = cycle number within the current frame (1..FL),
  // FL+1 is the done cycle, 0 is plain idle.
  int         m_t = 0;
  logic [9:0] m_frame = '1;

  always @(posedge clk) begin
    if (!rst_n) m_t <= 0;
    else if ((m_t == 0 || m_t == FL + 1) && bus.send_i) begin
      m_t     <= 1;
      m_frame <= {1'b1, bus.data_i, 1'b0};
    end else if (m_t >= 1 && m_t <= FL) m_t <= m_t + 1;
    else m_t <= 0;
  end

  function automatic logic [2:0] model_out();
    logic t, b, d;
    b = (m_t >= 1 && m_t <= FL);
    t = b ? m_frame[(m_t - 1) / CPB] : 1'b1;
    d = (m_t == FL + 1);
    return {t, b, d};
  endfunction

  logic tx_log [0:255];

  // Byte carried by a frame whose start bit begins in logged cycle s.
  function automatic logic [9:0] decode(input int s);
    logic [9:0] f;
    for (int j = 0; j < 10; j++) f[j] = tx_log[s + j * CPB + 1];
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.send_i = 1'b1;
    bus.data_i = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== 3'b100) begin
        failures++;
        $display("FAIL reset c=%0d got tx/busy/done=%b exp=100", c, {bus.tx_o, bus.busy_o, bus.done_o});
      end
    end
    bus.send_i = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== 3'b100) begin
        failures++;
        $display("FAIL reset_release c=%0d got=%b exp=100", c, {bus.tx_o, bus.busy_o, bus.done_o});
      end
    end
  endtask

  task automatic test_single();
    int busy_n = 0, done_n = 0, done_c = -1;
    bus.data_i = 8'hA5;
    bus.send_i = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      bus.send_i = 1'b0;
      tx_log[c] = bus.tx_o;
      busy_n += int'(bus.busy_o);
      if (bus.done_o) begin done_n++; done_c = c; end
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
        failures++;
        $display("FAIL single c=%0d got=%b exp=%b", c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
      end
    end
    checks++;
    if (decode(1) !== 10'b1_1010_0101_0) begin
      failures++;
      $display("FAIL single_frame got=%b exp=%b", decode(1), 10'b1_1010_0101_0);
    end
    checks++;
    if (busy_n != FL || done_n != 1 || done_c != FL + 1) begin
      failures++;
      $display("FAIL single_timing busy=%0d done_n=%0d done_c=%0d exp 40/1/41", busy_n, done_n, done_c);
    end
  endtask

  task automatic test_busy_ignore();
    int busy_n = 0, done_n = 0;
    bus.data_i = 8'hA5;
    bus.send_i = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      bus.send_i = (c == 20);
      bus.data_i = (c == 20) ? 8'h3C : 8'hA5;
      tx_log[c] = bus.tx_o;
      busy_n += int'(bus.busy_o);
      done_n += int'(bus.done_o);
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
        failures++;
        $display("FAIL busy_ignore c=%0d got=%b exp=%b", c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
      end
    end
    checks++;
    if (decode(1) !== 10'b1_1010_0101_0 || busy_n != FL || done_n != 1) begin
      failures++;
      $display("FAIL busy_ignore_sum frame=%b busy=%0d done=%0d exp frame=1101001010 busy=40 done=1", decode(1), busy_n, done_n);
    end
  endtask

  task automatic test_back_to_back();
    int dc[$];
    bus.data_i = 8'h00;
    bus.send_i = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      bus.data_i = 8'hFF;
      if (c == 42) bus.send_i = 1'b0;
      tx_log[c] = bus.tx_o;
      if (bus.done_o) dc.push_back(c);
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
        failures++;
        $display("FAIL b2b c=%0d got=%b exp=%b", c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
      end
    end
    checks++;
    if (decode(1) !== 10'b1_0000_0000_0 || decode(42) !== 10'b1_1111_1111_0) begin
      failures++;
      $display("FAIL b2b_frames got=%b,%b exp=1000000000,1111111110", decode(1), decode(42));
    end
    checks++;
    if (dc.size() != 2 || dc[0] != 41 || dc[1] != 82) begin
      failures++;
      $display("FAIL b2b_done n=%0d first=%0d exp n=2 at 41,82", dc.size(), (dc.size() > 0) ? dc[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    int done_n = 0;
    bus.data_i = 8'hC3;
    bus.send_i = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.send_i = 1'b0;
      rst_n = (c != 18);   // edge ending cycle 18 lands inside data bit 3
      done_n += int'(bus.done_o);
      if (c == 19) begin
        checks++;
        if ({bus.tx_o, bus.busy_o, bus.done_o} !== 3'b100) begin
          failures++;
          $display("FAIL mid_reset_abort got=%b exp=100", {bus.tx_o, bus.busy_o, bus.done_o});
        end
      end
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
        failures++;
        $display("FAIL mid_reset c=%0d got=%b exp=%b", c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
      end
    end
    checks++;
    if (done_n != 0) begin
      failures++;
      $display("FAIL mid_reset_done got=%0d exp=0", done_n);
    end
    bus.data_i = 8'h5A;
    bus.send_i = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      bus.send_i = 1'b0;
      tx_log[c] = bus.tx_o;
      checks++;
      if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
        failures++;
        $display("FAIL after_reset c=%0d got=%b exp=%b", c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
      end
    end
    checks++;
    if (decode(1) !== 10'b1_0101_1010_0) begin
      failures++;
      $display("FAIL after_reset_frame got=%b exp=%b", decode(1), 10'b1_0101_1010_0);
    end
  endtask

  // Random bytes with data_i scrambled every cycle after the sampling edge
  // and stray send pulses mid-frame; only the byte at the start edge counts.
  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.data_i = b;
      bus.send_i = 1'b1;
      for (int c = 1; c <= FL + 1; c++) begin
        @(negedge clk);
        bus.data_i = 8'($urandom);
        bus.send_i = (c > 3 && c < FL - 2) ? 1'($urandom) : 1'b0;
        tx_log[c] = bus.tx_o;
        checks++;
        if ({bus.tx_o, bus.busy_o, bus.done_o} !== model_out()) begin
          failures++;
          $display("FAIL random n=%0d c=%0d got=%b exp=%b", n, c, {bus.tx_o, bus.busy_o, bus.done_o}, model_out());
        end
      end
      checks++;
      if (decode(1) !== {1'b1, b, 1'b0}) begin
        failures++;
        $display("FAIL random_frame n=%0d got=%b exp=%b", n, decode(1), {1'b1, b, 1'b0});
      end
    end
  endtask

  initial begin
    bus.data_i = '0;
    bus.send_i = 1'b0;
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_uart_tx.md
Name: module_uart_tx

Overview:
- UART transmit serializer for the processor's UART peripheral.
- Sits directly downstream of the UART 2:1 data-select mux (module_mux_2_1, ANCHO=8). The mux output drives data_i.
- On a send request it latches the byte and emits one 8N1 frame on tx_o: start bit, 8 data bits LSB-first, stop bit.
- Reports busy and a one-cycle done pulse to the UART control/status register logic.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200). Legal range is >= 2; elaboration fails otherwise.
- DATA_W, 8, data bits per frame. Fixed at 8 in this revision.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- data_i  input  DATA_W  byte to transmit, from the UART data-select mux.
- send_i  input  1  send request. Sampled only in IDLE. Level or pulse both accepted.
- tx_o  output  1  serial line, registered, idles high.
- busy_o  output  1  high while a frame is in progress (START/DATA/STOP).
- done_o  output  1  one-cycle pulse on the first IDLE cycle after a frame completes.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - state=IDLE; tx_o=1, busy_o=0, done_o=0.
  - Baud counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame: tx_o returns to 1 on that edge and no done_o pulse is produced.
- FSM states are IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - tx_o=1, busy_o=0.
  - If send_i=1 at an edge: latch data_i into the shift register, go to START, cnt=0, tx_o<=0, busy_o<=1.
  - Later changes on data_i do not affect the frame in flight.
- START: tx_o=0 for exactly CLKS_PER_BIT cycles. At cnt==CLKS_PER_BIT-1: cnt<=0, go to DATA, tx_o<=shreg[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At cnt==CLKS_PER_BIT-1: shift right and bit index+1, tx_o<=next bit.
  - After bit 7: go to STOP, tx_o<=1.
- STOP:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE; busy_o<=0 and done_o<=1 in that same update.
- done_o:
  - High for exactly one cycle (the first IDLE cycle).
  - Cleared on the next edge regardless of send_i.
- Timing: with sampling edge E0, the frame occupies cycles 1..10*CLKS_PER_BIT, and done_o is high in cycle 10*CLKS_PER_BIT+1.
- send_i while busy_o=1 is ignored: no queuing, no error flag.
- Simultaneous done_o and send_i=1 in the first IDLE cycle starts the next frame at the following edge.
  - Minimum start-to-start period is 10*CLKS_PER_BIT+1 cycles.
  - The effective stop bit is therefore CLKS_PER_BIT+1 cycles.
- Counter widths:
  - cnt is $clog2(CLKS_PER_BIT) bits and wraps only via explicit clear at CLKS_PER_BIT-1. It never overflows.
  - Bit index is 3 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] tx_state_e {IDLE, START, DATA, STOP};
  - localparam UART_DATA_W=8;
  - localparam UART_CLKS_PER_BIT_DEFAULT=868.
  - The future module_uart_rx will share this package.
- One sub-module is natural: module_uart_baud_tick.
  - Ports: clk_i, rst_n_i, clr_i, tick_o.
  - Parameter CLKS_PER_BIT.
  - tick_o is high when the count equals CLKS_PER_BIT-1.
  - The TX FSM clears it on each state entry.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset: hold rst_n_i=0 for 3 cycles with send_i=1 -> tx_o=1, busy_o=0, done_o=0 throughout. No frame starts until after release.
- Single byte: data_i=0xA5, one-cycle send_i pulse -> tx_o bits 0,1,0,1,0,0,1,0,1,1, each exactly 4 cycles. busy_o high for cycles 1..40. done_o=1 only in cycle 41.
- Busy ignore: during the 0xA5 frame, pulse send_i with data_i=0x3C at cycle 20 -> frame still carries 0xA5 and exactly one done_o pulse. No second frame.
- Back-to-back: send_i held high with data_i=0x00, switched to 0xFF after the first start -> first frame all-zero data. The second start bit begins in cycle 42. Two done_o pulses, at cycles 41 and 82.
- Mid-frame reset: assert rst_n_i=0 during data bit 3 -> next cycle tx_o=1, busy_o=0, no done_o. A following send of 0x5A produces a correct full frame.
- Latch check: change data_i every cycle after the sampling edge -> the transmitted byte equals data_i as sampled at E0.
